// File: rtl/blueplayer_text_overlay_pkg.sv
// Shared constants for the text overlay: ASCII codes and glyph/row geometry.
package text_pkg;

  localparam logic [6:0] BLANK = 7'h20;
  localparam logic [6:0] DASH  = 7'h2D;
  localparam logic [6:0] ZERO  = 7'h30;
  localparam logic [6:0] COLON = 7'h3A;

  localparam int unsigned GLYPH_W   = 8;
  localparam int unsigned GLYPH_H   = 16;
  localparam int unsigned LABEL_LEN = 16;
  localparam int unsigned SCORE_LEN = 2;

  // Total pixel width of label plus score field.
  localparam int unsigned ROW_W = (LABEL_LEN + SCORE_LEN) * GLYPH_W;

endpackage

// File: rtl/bcd_to_ascii.sv
// BCD digit to ASCII code; values above 9 render as a dash.
//   digit_i : 4-bit BCD digit
//   code_o  : 7-bit ASCII code (combinational)
module bcd_to_ascii
  import text_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] code_o
);

  assign code_o = (digit_i > 4'd9) ? DASH : 7'(ZERO + 7'(digit_i));

endmodule

// File: rtl/blueplayer_text_overlay.sv
// Label row plus two-digit score renderer. Two-stage pixel pipeline:
// stage 1 registers the glyph code/row/bit, stage 2 samples the font word.
//   clk, reset_n         : clock, async active-low reset
//   p_tick               : pixel enable (>= 2 clk spacing)
//   video_on, pixel_x/y  : scan position
//   score_tens/ones      : BCD score, latched at frame start
//   blink_en             : blink score digits on frame_cnt[4]
//   char_xy / char_code  : label ROM address / data (combinational)
//   rom_addr / font_word : font ROM address / data (1 clk read latency)
//   text_on / text_rgb   : registered overlay pixel
module blueplayer_text_overlay
  import text_pkg::*;
#(
  parameter int unsigned X0       = 16,
  parameter int unsigned Y0       = 16,
  parameter logic [11:0] TEXT_RGB = 12'h00F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [3:0]  score_tens,
  input  logic [3:0]  score_ones,
  input  logic        blink_en,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] rom_addr,
  input  logic [7:0]  font_word,
  output logic        text_on,
  output logic [11:0] text_rgb
);

  localparam logic [9:0] X0_C    = 10'(X0);
  localparam logic [9:0] Y0_C    = 10'(Y0);
  localparam logic [9:0] ROW_W_C = 10'(ROW_W);
  localparam logic [9:0] GLYPH_H_C = 10'(GLYPH_H);
  localparam logic [4:0] LABEL_LEN_C = 5'(LABEL_LEN);

  logic [9:0]  dx, dy;
  logic        in_region;
  logic [4:0]  col;
  logic [3:0]  row;
  logic [2:0]  bit_idx;
  logic        frame_start;
  logic        blank_digits;
  logic [6:0]  tens_code, ones_code, sel_code;
  logic        pixel_hit;

  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [4:0]  frame_cnt_q, frame_cnt_d;
  logic [6:0]  code_q, code_d;
  logic [3:0]  row_q, row_d;
  logic [2:0]  bit_q, bit_d;
  logic        on_q, on_d;
  logic        text_on_q, text_on_d;
  logic [11:0] text_rgb_q, text_rgb_d;

  // Region and field decode; wrap-around subtraction keeps left/top edges exact.
  assign dx        = pixel_x - X0_C;
  assign dy        = pixel_y - Y0_C;
  assign in_region = video_on && (pixel_x >= X0_C) && (dx < ROW_W_C)
                     && (pixel_y >= Y0_C) && (dy < GLYPH_H_C);
  assign col       = dx[7:3];
  assign row       = dy[3:0];
  assign bit_idx   = dx[2:0];

  assign char_xy     = {3'b000, col};
  assign frame_start = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign blank_digits = blink_en && frame_cnt_q[4];

  bcd_to_ascii u_tens (.digit_i(tens_q), .code_o(tens_code));
  bcd_to_ascii u_ones (.digit_i(ones_q), .code_o(ones_code));

  // Label columns read the ROM; columns 16/17 (and beyond, unused) the score.
  always_comb begin
    sel_code = char_code;
    if (col >= LABEL_LEN_C) begin
      if (blank_digits) sel_code = BLANK;
      else              sel_code = col[0] ? ones_code : tens_code;
    end
  end

  assign rom_addr  = {code_q, row_q};
  assign pixel_hit = on_q && font_word[3'(3'd7 - bit_q)];

  // Next-state: everything advances only on p_tick.
  always_comb begin
    tens_d      = tens_q;
    ones_d      = ones_q;
    frame_cnt_d = frame_cnt_q;
    code_d      = code_q;
    row_d       = row_q;
    bit_d       = bit_q;
    on_d        = on_q;
    text_on_d   = text_on_q;
    text_rgb_d  = text_rgb_q;
    if (frame_start) begin
      tens_d      = score_tens;
      ones_d      = score_ones;
      frame_cnt_d = frame_cnt_q + 5'd1;
    end
    if (p_tick) begin
      code_d     = sel_code;
      row_d      = row;
      bit_d      = bit_idx;
      on_d       = in_region;
      text_on_d  = pixel_hit;
      text_rgb_d = pixel_hit ? TEXT_RGB : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_q      <= '0;
      ones_q      <= '0;
      frame_cnt_q <= '0;
      code_q      <= '0;
      row_q       <= '0;
      bit_q       <= '0;
      on_q        <= 1'b0;
      text_on_q   <= 1'b0;
      text_rgb_q  <= '0;
    end else begin
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      frame_cnt_q <= frame_cnt_d;
      code_q      <= code_d;
      row_q       <= row_d;
      bit_q       <= bit_d;
      on_q        <= on_d;
      text_on_q   <= text_on_d;
      text_rgb_q  <= text_rgb_d;
    end
  end

  assign text_on  = text_on_q;
  assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_blueplayer_text_overlay.sv
// Self-checking bench for blueplayer_text_overlay with label/font ROM stubs
// and a pixel-level reference model of the overlay.
module tb_blueplayer_text_overlay;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  score_tens, score_ones;
  logic        blink_en;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] rom_addr;
  logic [7:0]  font_word;
  logic        text_on;
  logic [11:0] text_rgb;

  int checks = 0;
  int failures = 0;
  int font_mode = 0;

  // Reference model state
  int m_tens, m_ones, m_fc;
  bit p_in;
  int p_code, p_row, p_bit;

  always #5 clk = ~clk;

  blueplayer_text_overlay dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .score_tens(score_tens),
    .score_ones(score_ones), .blink_en(blink_en), .char_xy(char_xy),
    .char_code(char_code), .rom_addr(rom_addr), .font_word(font_word),
    .text_on(text_on), .text_rgb(text_rgb)
  );

  function automatic logic [6:0] label_fn(input logic [7:0] a);
    string s;
    s = "BLUE player     ";
    if (a < 8'd16) return 7'(s[int'(a)]);
    return 7'h3F;
  endfunction

  function automatic logic [7:0] font_fn(input logic [10:0] a);
    int v;
    if (font_mode == 0) return 8'h81;
    v = (int'(a) * 37) ^ (int'(a) >> 3) ^ 'h5A;
    return 8'(v);
  endfunction

  assign char_code = label_fn(char_xy);
  always @(posedge clk) font_word <= font_fn(rom_addr);

  function automatic int digit_code(input int d);
    if (blink_en && m_fc >= 16) return 'h20;
    if (d > 9) return 'h2D;
    return 'h30 + d;
  endfunction

  // One pixel: present coordinates with a one-clk p_tick, leave one idle clk.
  task automatic tick(input int x, input int y, input bit vo);
    int dx, dy, col, row, bt, code;
    bit inreg, exp_on;
    logic [7:0] fw;
    logic [11:0] exp_rgb;
    logic [10:0] exp_addr;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo; p_tick = 1'b1;
    #1;
    dx = (x - 16) & 1023;
    dy = (y - 16) & 1023;
    col = (dx >> 3) & 31;
    row = dy & 15;
    bt = dx & 7;
    inreg = vo && x >= 16 && dx < 144 && y >= 16 && dy < 16;
    checks++;
    if (char_xy !== 8'(col)) begin
      failures++;
      $display("FAIL char_xy x=%0d: got %h expected %h", x, char_xy, 8'(col));
    end
    if (col < 16) code = int'(label_fn(8'(col)));
    else if (col == 16) code = digit_code(m_tens);
    else code = digit_code(m_ones);
    if (x == 0 && y == 0) begin
      m_tens = int'(score_tens);
      m_ones = int'(score_ones);
      m_fc = (m_fc + 1) % 32;
    end
    @(negedge clk);
    p_tick = 1'b0;
    fw = font_fn(11'({p_code[6:0], p_row[3:0]}));
    exp_on = p_in && fw[7 - p_bit];
    exp_rgb = exp_on ? 12'h00F : 12'h000;
    checks++;
    if (text_on !== exp_on) begin
      failures++;
      $display("FAIL text_on x=%0d y=%0d: got %b expected %b", x, y, text_on, exp_on);
    end
    checks++;
    if (text_rgb !== exp_rgb) begin
      failures++;
      $display("FAIL text_rgb x=%0d y=%0d: got %h expected %h", x, y, text_rgb, exp_rgb);
    end
    if (inreg) begin
      exp_addr = 11'({code[6:0], row[3:0]});
      checks++;
      if (rom_addr !== exp_addr) begin
        failures++;
        $display("FAIL rom_addr x=%0d y=%0d: got %h expected %h", x, y, rom_addr, exp_addr);
      end
    end
    p_in = inreg; p_code = code; p_row = row; p_bit = bt;
  endtask

  task automatic model_clear();
    m_tens = 0; m_ones = 0; m_fc = 0;
    p_in = 1'b0; p_code = 0; p_row = 0; p_bit = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; p_tick = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0; score_tens = '0; score_ones = '0; blink_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000 || rom_addr !== 11'h000) begin
      failures++;
      $display("FAIL reset_init: got on=%b rgb=%h addr=%h expected 0 0 0", text_on, text_rgb, rom_addr);
    end
    reset_n = 1'b1;
    model_clear();
    font_mode = 0;
    for (int x = 16; x < 24; x++) tick(x, 20, 1'b1);
    tick(17, 20, 1'b1);
    // Assert reset between clock edges and observe before any edge.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000 || rom_addr !== 11'h000) begin
      failures++;
      $display("FAIL reset_async: got on=%b rgb=%h addr=%h expected 0 0 0", text_on, text_rgb, rom_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_label();
    font_mode = 0;
    tick(16, 16, 1'b1);
    checks++;
    if (rom_addr !== {7'h42, 4'h0}) begin
      failures++;
      $display("FAIL label_addr: got %h expected %h", rom_addr, {7'h42, 4'h0});
    end
    for (int x = 17; x < 24; x++) tick(x, 16, 1'b1);
    for (int x = 24; x < 40; x++) tick(x, 16 + (x & 15), 1'b1);
    tick(0, 5, 1'b1);
    // Edges of the region.
    tick(15, 16, 1'b1); tick(159, 31, 1'b1); tick(160, 16, 1'b1);
    tick(20, 15, 1'b1); tick(20, 32, 1'b1); tick(20, 20, 1'b0);
  endtask

  task automatic test_score();
    font_mode = 0;
    score_tens = 4'd4; score_ones = 4'd7;
    tick(0, 0, 1'b0);
    tick(144, 16, 1'b1);
    checks++;
    if (rom_addr[10:4] !== 7'h34) begin
      failures++;
      $display("FAIL score_tens: got %h expected 34", rom_addr[10:4]);
    end
    tick(152, 17, 1'b1);
    checks++;
    if (rom_addr[10:4] !== 7'h37) begin
      failures++;
      $display("FAIL score_ones: got %h expected 37", rom_addr[10:4]);
    end
    score_ones = 4'hC;
    tick(0, 0, 1'b0);
    tick(155, 18, 1'b1);
    checks++;
    if (rom_addr[10:4] !== 7'h2D) begin
      failures++;
      $display("FAIL score_invalid: got %h expected 2d", rom_addr[10:4]);
    end
    tick(20, 20, 1'b1);
  endtask

  task automatic test_tearing();
    font_mode = 1;
    score_tens = 4'd1; score_ones = 4'd2;
    tick(0, 0, 1'b0);
    tick(145, 20, 1'b1);
    score_tens = 4'd8; score_ones = 4'd9;
    tick(146, 21, 1'b1);
    checks++;
    if (rom_addr[10:4] !== 7'h31) begin
      failures++;
      $display("FAIL tearing_hold: got %h expected 31", rom_addr[10:4]);
    end
    tick(153, 21, 1'b1);
    tick(0, 0, 1'b0);
    tick(147, 22, 1'b1);
    checks++;
    if (rom_addr[10:4] !== 7'h38) begin
      failures++;
      $display("FAIL tearing_update: got %h expected 38", rom_addr[10:4]);
    end
  endtask

  task automatic test_blink();
    logic [6:0] exp_code;
    font_mode = 1;
    blink_en = 1'b1;
    score_tens = 4'd5; score_ones = 4'd6;
    for (int f = 0; f < 40; f++) begin
      tick(0, 0, 1'b0);
      tick(144 + (f & 7), 16 + (f & 15), 1'b1);
      exp_code = (m_fc >= 16) ? 7'h20 : 7'h35;
      checks++;
      if (rom_addr[10:4] !== exp_code) begin
        failures++;
        $display("FAIL blink frame=%0d: got %h expected %h", m_fc, rom_addr[10:4], exp_code);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_random();
    int x, y;
    font_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) == 0) begin
        score_tens = 4'($urandom);
        score_ones = 4'($urandom);
      end
      if ($urandom_range(49) == 0) blink_en = 1'($urandom);
      if ($urandom_range(19) == 0) begin
        x = 0; y = 0;
      end else begin
        x = int'($urandom_range(175));
        y = int'($urandom_range(40));
      end
      tick(x, y, ($urandom_range(7) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_label();
    test_score();
    test_tearing();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blueplayer_text_overlay.md
# blueplayer_text_overlay

Reader and pixel renderer for the 16-character "BLUE player" label row, extended with a two-digit score field. It scans the VGA pixel coordinates, addresses the label character ROM (8-bit `char_xy` to 7-bit `char_code`), and addresses the external 8x16 font ROM. It emits a registered `text_on`/`text_rgb` pixel that the top-level RGB multiplexer overlays on the game graphics.

## Interface
- `X0`, default 16: left pixel column of the text row.
- `Y0`, default 16: top pixel line of the text row.
- `TEXT_RGB`, default 12'h00F: foreground colour.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `p_tick`  in  1: pixel enable, one `clk` wide. Consecutive ticks are at least 2 `clk` apart.
- `video_on`  in  1: active display area.
- `pixel_x`, `pixel_y`  in  10 each: current pixel coordinates.
- `score_tens`, `score_ones`  in  4 each: BCD score digits.
- `blink_en`  in  1: blink the score digits.
- `char_xy`  out  8: label ROM address (combinational).
- `char_code`  in  7: label ROM data (combinational ROM).
- `rom_addr`  out  11: font ROM address, `{code, row}`.
- `font_word`  in  8: font ROM data, valid 1 `clk` after `rom_addr`. Bit 7 is the leftmost pixel.
- `text_on`  out  1: registered pixel-on flag.
- `text_rgb`  out  12: registered colour. Equals `TEXT_RGB` when `text_on` is high, else 0.

## Operation
- Region: `dx = pixel_x - X0`, `dy = pixel_y - Y0` (10-bit unsigned). `in_region = video_on && pixel_x >= X0 && dx < 144 && pixel_y >= Y0 && dy < 16`.
- Field decode: `col = dx[7:3]` (0..17), `row = dy[3:0]`, `bit = dx[2:0]`.
- `char_xy = {3'b000, col}`, driven continuously. Outside the region it still follows `col`; the value is don't-care but must stay deterministic.
- Code select:
  - `col` 0..15 uses `char_code`.
  - `col` 16 uses the latched tens digit; `col` 17 uses the latched ones digit.
  - Digit mapping: `7'h30 + d` for d = 0..9; d > 9 gives `7'h2D` (dash).
  - Digits blanked (`7'h20`) while `blink_en && frame_cnt[4]`.
- Score latch: on a `p_tick` with `pixel_x == 0 && pixel_y == 0`:
  - load `score_tens` and `score_ones` into internal registers;
  - increment the 5-bit `frame_cnt`, wrapping 31 to 0.
  - Mid-frame score changes are not displayed until the next frame (no tearing).
- Stage 1, on `p_tick`:
  - `code_q` <= selected code;
  - `row_q` <= `row`; `bit_q` <= `bit`; `on_q` <= `in_region`.
  - `rom_addr = {code_q, row_q}`.
- Stage 2, on `p_tick`:
  - `text_on` <= `on_q && font_word[7 - bit_q]`;
  - `text_rgb` <= `TEXT_RGB` if that term is 1, else 0.
- Reset: every register clears asynchronously while `reset_n` is low. This covers `code_q`, `row_q`, `bit_q`, `on_q`, `text_on`, `text_rgb` (all 0), `rom_addr` (0), the latched digits (0) and `frame_cnt` (0). The block resumes on the first `p_tick` after release. No partial-frame recovery is needed; the first pixels may show a stale score of 0.

## Timing
- Latency: 2 `p_tick` from pixel coordinates to `text_on`/`text_rgb`. The top level delays `video_on` and sync by the same amount.
- `rom_addr` changes 1 `clk` after the stage-1 `p_tick`.
- `font_word` is valid 1 `clk` later, which is at or before the next `p_tick` because of the 2-`clk` tick spacing. A spacing of 1 `clk` is illegal.
- Simultaneous frame-start latch and a region pixel: impossible when `Y0 > 0`. When `Y0 = 0` and `X0 = 0`, pixel (0,0) uses the newly latched digits only from `col` 16 onward, which is consistent.
- No register changes between `p_tick` pulses except `rom_addr` settling and the reset response.

## Structure
- Shared package `text_pkg`:
  - ASCII constants: `BLANK` 7'h20, `DASH` 7'h2D, `ZERO` 7'h30, `COLON` 7'h3A;
  - `GLYPH_W` = 8, `GLYPH_H` = 16, `LABEL_LEN` = 16, `SCORE_LEN` = 2.
- Sub-module `bcd_to_ascii`: 4-bit digit in, 7-bit code out, maps d > 9 to dash. It is instantiated twice.
- The label ROM and the font ROM are external instances.

## Test plan
- Reset asserted mid-line, `reset_n` = 0: `text_on` = 0, `text_rgb` = 0, `rom_addr` = 0 immediately, without waiting for `clk`.
- Label read, `pixel_y` = 16, `pixel_x` = 16..23 with font stub returning 8'h81: `char_xy` = 0, then `rom_addr` = {7'h42, 4'h0}. `text_on` goes 1,0,0,0,0,0,0,1 two ticks later.
- Score digits: `score_tens` = 4, `score_ones` = 7, latched at frame start; `pixel_x` at columns 16 and 17 gives `rom_addr` code 7'h34 then 7'h37.
- Invalid BCD: `score_ones` = 4'hC gives code 7'h2D at column 17.
- Tearing: change the score mid-frame; the displayed code stays at the old value until after the next (0,0) tick.
- Blink: `blink_en` = 1; digits show as 7'h20 for frames 16..31 of each 32 and as digits for frames 0..15. `frame_cnt` wraps 31 to 0.
